board_rst_seq: RTL

Parametrised reset sequencer for board top levels. It sits between the clock generator and the core. It merges NUM_SRC external reset requests, each with its own polarity (buttons, header reset pins). It synchronises and debounces them, holds reset for a programmable time, then releases NUM_OUT active-low domain resets in a staged order. It records which source caused the last reset.

---
 rtl/board_rst_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/board_rst_seq.sv
// Board reset sequencer: synchronises and debounces reset requests, holds reset,
// then releases active-low domain resets in a staged order and records the cause.
module board_rst_seq #(
  parameter int                 NUM_SRC         = 2,
  parameter logic [NUM_SRC-1:0] SRC_ACT_LOW     = NUM_SRC'(2'b01),
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter int                 HOLD_CYCLES     = 16,
  parameter int                 NUM_OUT         = 3,
  parameter int                 STAGE_GAP       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  output logic [NUM_OUT-1:0] rst_n_o,
  output logic               done,
  output logic [NUM_SRC-1:0] cause,
  output logic [NUM_SRC-1:0] src_act
);

  // state   | meaning
  // S_HOLD  | all domains in reset, waiting for HOLD_CYCLES quiet edges
  // S_RELEASE | releasing one domain every STAGE_GAP edges
  // S_RUN   | all domains released, watching for new requests
  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_e;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam logic [NUM_OUT-1:0] ONE = NUM_OUT'(1);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, s;
  logic [NUM_SRC-1:0] src_act_q, src_act_d, cause_q, cause_d;
  logic [DW-1:0]      deb_q [NUM_SRC];
  logic [DW-1:0]      deb_d [NUM_SRC];
  logic [HW-1:0]      hold_q, hold_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic               any_act, reenter;

  // Sync flops reset to each pin's idle level so no spurious request follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= SRC_ACT_LOW;
      sync2_q   <= SRC_ACT_LOW;
      src_act_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) deb_q[i] <= '0;
    end else begin
      sync1_q   <= src;
      sync2_q   <= sync1_q;
      src_act_q <= src_act_d;
      for (int i = 0; i < NUM_SRC; i++) deb_q[i] <= deb_d[i];
    end
  end

  assign s = sync2_q ^ SRC_ACT_LOW;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      deb_d[i]     = '0;
      src_act_d[i] = 1'b0;
      if (s[i]) begin
        deb_d[i]     = (deb_q[i] == DW'(DEBOUNCE_CYCLES)) ? deb_q[i] : deb_q[i] + 1'b1;
        src_act_d[i] = (deb_d[i] == DW'(DEBOUNCE_CYCLES));
      end
    end
  end

  assign any_act = |src_act_q;
  assign reenter = any_act && (state_q != S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (reenter) begin
      // A new request beats any release scheduled for the same edge.
      state_d = S_HOLD;
      rst_n_d = '0;
      done_d  = 1'b0;
      cause_d = src_act_q;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          rst_n_d = '0;
          done_d  = 1'b0;
          if (any_act) begin
            hold_d = '0;
          end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            hold_d  = HW'(HOLD_CYCLES);
            gap_d   = '0;
            rst_n_d = ONE;
            if (NUM_OUT == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (gap_q == GW'(STAGE_GAP - 1)) begin
            gap_d   = '0;
            // Thermometer shift keeps releases strictly in bit order.
            rst_n_d = (rst_n_q << 1) | ONE;
            if (&rst_n_d) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_RUN:   ;
        default: state_d = S_HOLD;
      endcase
    end
  end

  assign rst_n_o = rst_n_q;
  assign done    = done_q;
  assign cause   = cause_q;
  assign src_act = src_act_q;

endmodule
